gaplus_inp_cond: RTL
====================

Name: gaplus_inp_cond

Overview:
Input conditioning stage between the player-input mux (USB/DB9/DB15 joystick merge) and the Gaplus core's INP0/INP1/INP2 inputs.
- Synchronises raw control bits and debounces them.
- Neutralises opposing-direction inputs (SOCD).
- Converts coin presses into frame-timed coin pulses with lockout, using vertical blank from the video timing generator.
- Replaces the direct combinational joystick-to-INPx wiring.

Parameters:
- DEB_CYCLES, 48000, MCLK cycles an input must hold a new level before it is accepted (1 ms at 48 MHz); legal range 2..65535.
- COIN_FRAMES, 4, coin pulse high time in frames.
- COIN_GAP, 4, forced low time after a coin pulse, in frames.
- SOCD_NEUTRAL, 1, 1 = opposing directions both pressed read as neither; 0 = pass through.

Ports:
- MCLK  in  1  system clock (48 MHz)
- RESET_N  in  1  asynchronous active-low reset
- VBLK  in  1  vertical blank from the timing generator, MCLK-synchronous level
- RAW_P1  in  5  {trig,left,down,right,up}, active-high, may be asynchronous
- RAW_P2  in  5  same layout, player 2
- RAW_COIN  in  2  {coin2,coin1}, active-high, asynchronous
- RAW_START  in  2  {start2,start1}, active-high, asynchronous
- INP0  out  5  conditioned P1 {trig,left,down,right,up}
- INP1  out  5  conditioned P2, same layout
- INP2  out  3  {coin,start2,start1}
- COIN_CNT  out  8  accepted coin pulses, wraps 255->0

Behaviour:
- Reset (async assert, sync-release irrelevant) state:
  - all outputs 0, synchroniser flops 0, stable levels 0, debounce counters 0
  - both coin FSMs IDLE, pending flags 0, COIN_CNT 0
  - vblk_q = 1, so no frame tick until VBLK has been seen low.
- Synchroniser: 2-flop on all 14 raw bits.
- Debounce, per bit, 16-bit counter:
  - synced == stable: counter <= 0.
  - otherwise: counter increments; when counter == DEB_CYCLES-1, stable <= synced and counter <= 0.
  - A glitch shorter than DEB_CYCLES cycles never reaches stable.
  - Raw edge held steady appears on INPx exactly DEB_CYCLES+3 MCLK edges later: 2 sync + DEB_CYCLES count + 1 output register.
- SOCD (SOCD_NEUTRAL=1), per player, combinational on stable levels before the output register:
  - up&down both set -> both 0.
  - left&right both set -> both 0.
  - trig is unaffected.
- Frame tick: single-cycle pulse when VBLK=1 and vblk_q=0 (rising edge); vblk_q <= VBLK every cycle.
- Coin FSM (one per coin), states IDLE, PULSE, GAP; 4-bit frame counter fc.
  - Coin edge = debounced coin stable rising edge.
  - IDLE: on edge -> PULSE, fc<=0, COIN_CNT increments.
  - PULSE: pulse_out=1; on tick fc++; when fc==COIN_FRAMES-1 and tick -> GAP, fc<=0.
  - GAP: pulse_out=0; on tick fc++; when fc==COIN_GAP-1 and tick:
    - pending=1 -> PULSE, pending<=0, COIN_CNT increments
    - otherwise -> IDLE.
  - Edge in PULSE/GAP sets pending (1 deep); further edges while pending=1 are dropped.
  - The edge arriving on the same cycle as GAP->IDLE is taken as an IDLE edge: it goes to PULSE the next cycle.
- INP2[2] = registered (pulse1 | pulse2).
- COIN_CNT adds 1 per FSM entering PULSE. Both FSMs entering on the same cycle adds 2.
- INP0/INP1/INP2[1:0] are registered from SOCD/stable values.
- VBLK stuck high or low: no ticks; coin FSMs hold state indefinitely. Joystick paths are unaffected.
- RESET_N asserted mid-pulse: INP2[2] drops to 0 immediately (async); pending is lost.

Decomposition:
- Shared package gaplus_inp_pkg holds:
  - coin_state_t enum {IDLE,PULSE,GAP}
  - bit index constants IDX_UP=0, IDX_RIGHT=1, IDX_DOWN=2, IDX_LEFT=3, IDX_TRIG=4
  - INP2 indices IDX_START1=0, IDX_START2=1, IDX_COIN=2
- One sub-module coin_pulser (FSM + fc + pending), instantiated twice.
- Debounce is a generate loop in the top.

Test Plan:
1. DEB_CYCLES=4. Raise RAW_P1[0], hold -> INP0[0]=1 exactly 7 edges later. A 3-cycle pulse on RAW_P1[1] -> INP0[1] stays 0.
2. SOCD_NEUTRAL=1. RAW_P1 up+down+trig = 5'b10101 -> INP0 = 5'b10000. Release down -> INP0 = 5'b10001 after 7 edges.
3. COIN_FRAMES=4, COIN_GAP=4, VBLK period 100 cycles.
   - Press coin1 once -> INP2[2] high for exactly 4 ticks, then low for 4 ticks; COIN_CNT=1.
4. Coin1 edge during PULSE, then a third edge during GAP -> exactly one extra pulse follows the gap; COIN_CNT=2 (third edge dropped).
5. Coin1 and coin2 edges on the same cycle -> single merged INP2[2] pulse; COIN_CNT=2. Then 255 more accepted pulses -> COIN_CNT wraps to 1.
6. Assert RESET_N low during PULSE -> INP2[2]=0 and COIN_CNT=0 immediately.
   - Release with VBLK held 1 -> no tick and no pulse until VBLK goes 0 then 1.

Source files
------------

// File: rtl/gaplus_inp_pkg.sv
// Shared types and bit positions for the Gaplus input conditioning stage.
// The SOCD helper lives here so both player paths use the same rule.
package gaplus_inp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

    localparam int IDX_UP    = 0;
    localparam int IDX_RIGHT = 1;
    localparam int IDX_DOWN  = 2;
    localparam int IDX_LEFT  = 3;
    localparam int IDX_TRIG  = 4;

    localparam int IDX_START1 = 0;
    localparam int IDX_START2 = 1;
    localparam int IDX_COIN   = 2;

    // Opposing directions cancel; a single direction or the trigger passes through.
    function automatic logic [4:0] socd_clean(input logic [4:0] d);
        logic [4:0] r;
        r[IDX_TRIG]  = d[IDX_TRIG];
        r[IDX_UP]    = d[IDX_UP]    & ~d[IDX_DOWN];
        r[IDX_DOWN]  = d[IDX_DOWN]  & ~d[IDX_UP];
        r[IDX_LEFT]  = d[IDX_LEFT]  & ~d[IDX_RIGHT];
        r[IDX_RIGHT] = d[IDX_RIGHT] & ~d[IDX_LEFT];
        return r;
    endfunction

endpackage

// File: rtl/gaplus_inp_cond_if.sv
// Link between the input stage and one coin pulser: the stage supplies the
// debounced coin edge and frame tick, the pulser returns its pulse and entry strobe.
interface gaplus_inp_cond_if;

    logic coin_edge;
    logic frame_tick;
    logic pulse;
    logic enter;

    modport master (
        output coin_edge,
        output frame_tick,
        input  pulse,
        input  enter
    );

    modport slave (
        input  coin_edge,
        input  frame_tick,
        output pulse,
        output enter
    );

endinterface

// File: rtl/gaplus_inp_cond_coin.sv
// Coin pulser: turns a debounced coin edge into a frame-timed pulse followed by
// a forced gap, with a one-deep pending slot for edges seen while busy.
module coin_pulser
    import gaplus_inp_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_GAP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gaplus_inp_cond_if.slave   cp
);

    localparam logic [3:0] PULSE_LAST = 4'(COIN_FRAMES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(COIN_GAP - 1);

    coin_state_t state_q, state_d;
    logic [3:0]  fc_q, fc_d;
    logic        pending_q, pending_d;
    logic        pulse_q;
    logic        enter_c;

    // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        fc_d      = fc_q;
        pending_d = pending_q;
        enter_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pending flag here is an edge that landed on the GAP->IDLE cycle.
                if (cp.coin_edge || pending_q) begin
                    state_d   = PULSE;
                    fc_d      = '0;
                    pending_d = 1'b0;
                    enter_c   = 1'b1;
                end
            end
            PULSE: begin
                if (cp.coin_edge) pending_d = 1'b1;
                if (cp.frame_tick) begin
                    if (fc_q == PULSE_LAST) begin
                        state_d = GAP;
                        fc_d    = '0;
                    end else begin
                        fc_d = fc_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (cp.coin_edge) pending_d = 1'b1;
                if (cp.frame_tick) begin
                    if (fc_q == GAP_LAST) begin
                        fc_d = '0;
                        if (pending_q) begin
                            state_d   = PULSE;
                            pending_d = 1'b0;
                            enter_c   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        fc_d = fc_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fc_q      <= '0;
            pending_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fc_q      <= fc_d;
            pending_q <= pending_d;
            pulse_q   <= (state_d == PULSE);
        end
    end

    assign cp.pulse = pulse_q;
    assign cp.enter = enter_c;

endmodule

// File: rtl/gaplus_inp_cond.sv
// Gaplus input conditioning: synchronise, debounce and SOCD-clean the player
// controls, and turn coin presses into frame-timed pulses for INP2.
module gaplus_inp_cond
    import gaplus_inp_pkg::*;
#(
    parameter int DEB_CYCLES   = 48000,
    parameter int COIN_FRAMES  = 4,
    parameter int COIN_GAP     = 4,
    parameter bit SOCD_NEUTRAL = 1'b1
) (
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic       VBLK,
    input  logic [4:0] RAW_P1,
    input  logic [4:0] RAW_P2,
    input  logic [1:0] RAW_COIN,
    input  logic [1:0] RAW_START,
    output logic [4:0] INP0,
    output logic [4:0] INP1,
    output logic [2:0] INP2,
    output logic [7:0] COIN_CNT
);

    localparam int         NRAW     = 14;
    localparam int         B_P2     = 5;
    localparam int         B_COIN   = 10;
    localparam int         B_START  = 12;
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic [NRAW-1:0] raw, sync1_q, sync2_q, stable;

    assign raw = {RAW_START, RAW_COIN, RAW_P2, RAW_P1};

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // A bit is accepted only after the synced level differs for DEB_CYCLES straight cycles.
    for (genvar i = 0; i < NRAW; i++) begin : g_deb
        logic [15:0] cnt_q, cnt_d;
        logic        stable_q, stable_d;

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (sync2_q[i] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
                stable_d = sync2_q[i];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge MCLK or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable[i] = stable_q;
    end

    logic [1:0] coin_stable, coin_prev_q, coin_edge;
    logic       vblk_q, frame_tick;

    assign coin_stable = stable[B_COIN +: 2];
    assign coin_edge   = coin_stable & ~coin_prev_q;
    assign frame_tick  = VBLK & ~vblk_q;

    // vblk_q resets high so a VBLK already high at release is not mistaken for a new frame.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            coin_prev_q <= '0;
            vblk_q      <= 1'b1;
        end else begin
            coin_prev_q <= coin_stable;
            vblk_q      <= VBLK;
        end
    end

    gaplus_inp_cond_if coin1_if ();
    gaplus_inp_cond_if coin2_if ();

    assign coin1_if.coin_edge  = coin_edge[0];
    assign coin1_if.frame_tick = frame_tick;
    assign coin2_if.coin_edge  = coin_edge[1];
    assign coin2_if.frame_tick = frame_tick;

    coin_pulser #(
        .COIN_FRAMES (COIN_FRAMES),
        .COIN_GAP    (COIN_GAP)
    ) u_coin1 (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .cp    (coin1_if.slave)
    );

    coin_pulser #(
        .COIN_FRAMES (COIN_FRAMES),
        .COIN_GAP    (COIN_GAP)
    ) u_coin2 (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .cp    (coin2_if.slave)
    );

    logic [4:0] inp0_q, inp0_d, inp1_q, inp1_d;
    logic [2:0] inp2_q, inp2_d;
    logic [7:0] coin_cnt_q, coin_cnt_d;

    always_comb begin
        inp0_d = SOCD_NEUTRAL ? socd_clean(stable[4:0]) : stable[4:0];
        inp1_d = SOCD_NEUTRAL ? socd_clean(stable[B_P2 +: 5]) : stable[B_P2 +: 5];
        inp2_d             = '0;
        inp2_d[IDX_START1] = stable[B_START];
        inp2_d[IDX_START2] = stable[B_START + 1];
        inp2_d[IDX_COIN]   = coin1_if.pulse | coin2_if.pulse;
        coin_cnt_d = coin_cnt_q + 8'(coin1_if.enter) + 8'(coin2_if.enter);
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inp0_q     <= '0;
            inp1_q     <= '0;
            inp2_q     <= '0;
            coin_cnt_q <= '0;
        end else begin
            inp0_q     <= inp0_d;
            inp1_q     <= inp1_d;
            inp2_q     <= inp2_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    assign INP0     = inp0_q;
    assign INP1     = inp1_q;
    assign INP2     = inp2_q;
    assign COIN_CNT = coin_cnt_q;

endmodule
